// File: rtl/jt12_mixn_pkg.sv
// Shared types and helpers for the jt12_mixn mixer: FSM states, saturation and accumulator sizing.
package jt12_mixn_pkg;

  typedef enum logic [1:0] {IDLE, ACC, SAT, DCB} state_t;

  // Sum of CH signed*unsigned products never overflows this width.
  function automatic int acc_width(input int inw, input int gw, input int ch);
    return inw + gw + 1 + $clog2(ch);
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/jt12_mixn_dcblk.sv
// DC-blocking high-pass stage: y[n] = x[n] - x[n-1] + y[n-1] - y[n-1]/256, saturated to W bits.
// Used by jt12_mixn only when JT12_MIXN_DCBLOCK_EN is defined.
module jt12_mixn_dcblk
  import jt12_mixn_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic signed [W-1:0] x,
  input  logic                clip_in,
  output logic signed [W-1:0] y,
  output logic                valid,
  output logic                clip
);

  localparam int EW = W + 8;

  logic signed [W-1:0]  x_prev;
  logic signed [EW-1:0] sum;
  logic signed [63:0]   sum64;
  logic signed [63:0]   y_sat;

  always_comb begin
    sum   = EW'(x) - EW'(x_prev) + EW'(y) - EW'(y >>> 8);
    sum64 = 64'(sum);
    y_sat = sat(sum64, W);
  end

  // y doubles as the y[n-1] history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_prev <= '0;
      y      <= '0;
      valid  <= 1'b0;
      clip   <= 1'b0;
    end else begin
      valid <= en;
      clip  <= en & (clip_in | (y_sat != sum64));
      if (en) begin
        x_prev <= x;
        y      <= y_sat[W-1:0];
      end
    end
  end

endmodule

// File: rtl/jt12_mixn.sv
// jt12_mixn: N-channel mixer with per-channel gain/mute, one sequential MAC and output saturation.
// Define JT12_MIXN_DCBLOCK_EN to append the DC-blocking output stage (one extra cycle of latency).
module jt12_mixn
  import jt12_mixn_pkg::*;
#(
  parameter int CH    = 4,
  parameter int INW   = 16,
  parameter int GW    = 8,
  parameter int GFRAC = 4,
  parameter int OUTW  = 16,
  parameter int DIV   = 1008
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CH-1:0]          cen_in,
  input  logic [CH*INW-1:0]      snd_in,
  input  logic [CH*GW-1:0]       gain,
  input  logic [CH-1:0]          ch_en,
  output logic signed [OUTW-1:0] snd_out,
  output logic                   snd_valid,
  output logic                   clip,
  output logic                   overrun,
  output logic                   busy
);

  localparam int ACCW = acc_width(INW, GW, CH);
  localparam int PW   = INW + GW + 1;
  localparam int IW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int CW   = $clog2(DIV);

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt;
  logic                   tick;
  logic [IW-1:0]          idx;
  logic signed [INW-1:0]  lat  [CH];
  logic signed [INW-1:0]  snap [CH];
  logic signed [ACCW-1:0] acc;
  logic signed [PW-1:0]   prod;
  logic signed [63:0]     shifted, sat_val;
  logic                   sat_clip;
  logic signed [OUTW-1:0] sat_q;
  logic                   sat_vld_q, sat_clip_q;

  assign tick = (cnt == CW'(DIV - 1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) lat[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++)
        if (cen_in[i]) lat[i] <= snd_in[i*INW +: INW];
    end
  end

  // Gain is zero-extended so the product stays signed*unsigned.
  always_comb begin
    prod     = PW'(snap[idx]) * PW'($signed({1'b0, gain[idx*GW +: GW]}));
    shifted  = 64'(acc) >>> GFRAC;
    sat_val  = sat(shifted, OUTW);
    sat_clip = (sat_val != shifted);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (tick) state_nx = ACC;
      ACC:  if (idx == IW'(CH - 1)) state_nx = SAT;
`ifdef JT12_MIXN_DCBLOCK_EN
      SAT:  state_nx = DCB;
`else
      SAT:  state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Ticks landing outside IDLE are dropped; the running mix is left untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) snap[i] <= '0;
      acc        <= '0;
      idx        <= '0;
      overrun    <= 1'b0;
      sat_q      <= '0;
      sat_vld_q  <= 1'b0;
      sat_clip_q <= 1'b0;
    end else begin
      sat_vld_q  <= 1'b0;
      sat_clip_q <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          for (int i = 0; i < CH; i++) snap[i] <= lat[i];
          acc <= '0;
          idx <= '0;
        end
        ACC: begin
          acc <= acc + (ch_en[idx] ? ACCW'(prod) : ACCW'(0));
          idx <= idx + 1'b1;
        end
        SAT: begin
          sat_q      <= sat_val[OUTW-1:0];
          sat_vld_q  <= 1'b1;
          sat_clip_q <= sat_clip;
        end
        default: ;
      endcase
    end
  end

  // snd_valid is a one-cycle strobe qualifying snd_out; there is no ready,
  // so the consumer must take every valid sample. snd_out holds between strobes.
`ifdef JT12_MIXN_DCBLOCK_EN
  jt12_mixn_dcblk #(.W(OUTW)) u_dcblk (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (sat_vld_q),
    .x       (sat_q),
    .clip_in (sat_clip_q),
    .y       (snd_out),
    .valid   (snd_valid),
    .clip    (clip)
  );
`else
  assign snd_out   = sat_q;
  assign snd_valid = sat_vld_q;
  assign clip      = sat_clip_q;
`endif

endmodule

// File: tb/tb_jt12_mixn.sv
// Bench for jt12_mixn: behavioural mix model with per-cycle compare plus literal directed vectors.
module tb_jt12_mixn;

  localparam int CH = 4, INW = 16, GW = 8, GFRAC = 4, OUTW = 16, DIV = 20, DIV_O = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CH-1:0]     cen_in = '0;
  logic [CH-1:0]     ch_en = '0;
  logic [CH*INW-1:0] snd_in = '0;
  logic [CH*GW-1:0]  gain = '0;
  logic signed [OUTW-1:0] snd_out, o_out;
  logic snd_valid, clip, overrun, busy;
  logic o_valid, o_clip, o_overrun, o_busy;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  jt12_mixn #(.CH(CH), .INW(INW), .GW(GW), .GFRAC(GFRAC), .OUTW(OUTW), .DIV(DIV)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen_in(cen_in), .snd_in(snd_in), .gain(gain), .ch_en(ch_en),
    .snd_out(snd_out), .snd_valid(snd_valid), .clip(clip), .overrun(overrun), .busy(busy));

  jt12_mixn #(.CH(CH), .INW(INW), .GW(GW), .GFRAC(GFRAC), .OUTW(OUTW), .DIV(DIV_O)) u_ovr (
    .clk(clk), .rst_n(rst_n), .cen_in(cen_in), .snd_in(snd_in), .gain(gain), .ch_en(ch_en),
    .snd_out(o_out), .snd_valid(o_valid), .clip(o_clip), .overrun(o_overrun), .busy(o_busy));

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_cnt;
  longint m_cyc, m_acc_e;
  logic   m_ovr;
  logic signed [INW-1:0]  m_lat [CH];
  logic signed [OUTW-1:0] m_out;
  logic   m_clip, c_exp_v;
  logic [OUTW:0] exp_q[$];
  longint        due_q[$];

  function automatic logic [OUTW:0] model_mix();
    longint sum, r, hi, lo;
    sum = 0;
    for (int i = 0; i < CH; i++)
      if (ch_en[i]) sum += longint'(m_lat[i]) * longint'(gain[i*GW +: GW]);
    r  = sum >>> GFRAC;
    hi = (longint'(1) <<< (OUTW - 1)) - 1;
    lo = -(longint'(1) <<< (OUTW - 1));
    if (r > hi) return {1'b1, OUTW'(hi)};
    if (r < lo) return {1'b1, OUTW'(lo)};
    return {1'b0, OUTW'(r)};
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cnt = 0; m_cyc = 0; m_acc_e = -1000; m_ovr = 1'b0; m_out = '0;
      for (int i = 0; i < CH; i++) m_lat[i] = '0;
      exp_q.delete(); due_q.delete();
    end else begin
      m_cyc++;
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        if (m_cyc >= m_acc_e + CH + 1) begin
          m_acc_e = m_cyc;
          exp_q.push_back(model_mix());
          due_q.push_back(m_cyc + CH + 1);
        end else m_ovr = 1'b1;
      end else m_cnt++;
      for (int i = 0; i < CH; i++)
        if (cen_in[i]) m_lat[i] = snd_in[i*INW +: INW];
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk); #1;
    if (rst_n) begin
      c_exp_v = (due_q.size() != 0 && due_q[0] == m_cyc);
      m_clip = 1'b0;
      if (c_exp_v) begin
        m_out  = exp_q[0][OUTW-1:0];
        m_clip = exp_q[0][OUTW];
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      check("cyc_valid", snd_valid, c_exp_v);
      check("cyc_out", snd_out, m_out);
      check("cyc_clip", clip, m_clip);
      check("cyc_busy", busy, (m_cyc >= m_acc_e && m_cyc <= m_acc_e + CH));
      check("cyc_overrun", overrun, m_ovr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input int s0, s1, s2, s3, input int g0, g1, g2, g3, input logic [3:0] en);
    snd_in = {INW'(s3), INW'(s2), INW'(s1), INW'(s0)};
    gain   = {GW'(g3), GW'(g2), GW'(g1), GW'(g0)};
    ch_en  = en;
    cen_in = '1;
    @(negedge clk);
    cen_in = '0;
  endtask

  task automatic wait_valid(input string name, output logic signed [OUTW-1:0] v, output logic c);
    bit got = 0;
    v = '0; c = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk); #1;
      if (snd_valid) begin got = 1; v = snd_out; c = clip; end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: no snd_valid within 100 cycles", name);
    end
  endtask

  task automatic run_vec(input string name, input int s0, s1, s2, s3, input int g0, g1, g2, g3,
                         input logic [3:0] en, input int exp, input logic exp_clip);
    logic signed [OUTW-1:0] v;
    logic c;
    load(s0, s1, s2, s3, g0, g1, g2, g3, en);
    wait_valid(name, v, c);
    check(name, v, exp);
    check({name, "_clip"}, c, exp_clip);
  endtask

  task automatic wait_pre_tick(input string name);
    bit got = 0;
    for (int k = 0; k < 3 * DIV && !got; k++) begin
      @(negedge clk); #1;
      if (m_cnt == DIV - 1) got = 1;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: divider phase not found", name);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic signed [OUTW-1:0] v;
  logic c, prev_ovr, o_got;

  initial begin
    @(negedge clk); #1;
    check("rst_out", snd_out, 0);
    check("rst_valid", snd_valid, 0);
    check("rst_clip", clip, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr_out", o_out, 0);
    check("rst_ovr_flags", {o_valid, o_clip, o_overrun, o_busy, overrun}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load(100, 200, -50, 0, 16, 16, 16, 16, 4'hF);

    // DIV=5 instance: second tick lands in SAT
    prev_ovr = 1'b0; o_got = 1'b0;
    for (int k = 0; k < 40 && !o_got; k++) begin
      @(negedge clk); #1;
      if (o_valid) o_got = 1'b1;
      else prev_ovr = o_overrun;
    end
    check("ovr_got_valid", o_got, 1);
    check("ovr_first_out", o_out, 250);
    check("ovr_before", prev_ovr, 0);
    check("ovr_set", o_overrun, 1);

    wait_valid("unity", v, c);
    check("unity", v, 250);
    check("unity_clip", c, 0);

    run_vec("gain_mute", 1000, 1000, 9999, 9999, 32, 8, 16, 16, 4'b0011, 2500, 0);
    run_vec("sat_pos", 32767, 32767, 32767, 32767, 255, 255, 255, 255, 4'hF, 32767, 1);
    run_vec("sat_neg", -32768, -32768, -32768, -32768, 255, 255, 255, 255, 4'hF, -32768, 1);
    run_vec("edge_max", 32767, 0, 0, 0, 16, 16, 16, 16, 4'b0001, 32767, 0);
    run_vec("edge_over", 32767, 1, 0, 0, 16, 16, 16, 16, 4'b0011, 32767, 1);
    run_vec("floor_neg", -1, 0, 0, 0, 8, 8, 8, 8, 4'b0001, -1, 0);
    run_vec("mute_all", 5, 5, 5, 5, 16, 16, 16, 16, 4'b0000, 0, 0);
    run_vec("snap_pre", 100, 0, 0, 0, 16, 16, 16, 16, 4'b0001, 100, 0);

    // new sample latched on the very tick edge must miss that snapshot
    wait_pre_tick("snap_phase");
    snd_in[0 +: INW] = INW'(500);
    cen_in = 4'b0001;
    @(negedge clk);
    cen_in = '0;
    wait_valid("snap_old", v, c);
    check("snap_old", v, 100);
    wait_valid("snap_new", v, c);
    check("snap_new", v, 500);
    check("ovr_sticky", o_overrun, 1);

    // reset while idx==2
    wait_pre_tick("rst_phase");
    repeat (3) @(negedge clk);
    check("busy_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", snd_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", snd_valid, 0);
    check("mid_rst_ovr", o_overrun, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec("post_rst", 1234, -234, 0, 0, 16, 16, 16, 16, 4'b0011, 1000, 0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
